// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core's load/store path and the data-memory responder.
// The master drives requests and response acceptance; the slave answers.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Handshaked multi-cycle data-memory slave: one request at a time, LATENCY wait states, LE byte/half/word access.
// Latency: response valid LATENCY+2 cycles after accept; backpressure holds RESP indefinitely. Option: DMEM_MISALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int MEM_AW  = 12,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic                rdy_en;
    logic                accept;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [MEM_AW-1:0]   idx0, idx1, idx2, idx3;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic                illegal_f3, misal, acc_err;
    logic [31:0]         load_data;
    logic [7:0]          b0, b1, b2, b3;
    logic [7:0]          mem [0:(1 << MEM_AW) - 1];
    logic                unused_addr;

    assign unused_addr = ^bus.req_addr[31:MEM_AW];

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = rdy_en;
                if (bus.req_valid && rdy_en) begin
                    accept    = 1'b1;
                    state_nxt = (LATENCY > 0) ? WAIT : ACCESS;
                end
            end
            WAIT:   if (cnt == 4'd0) state_nxt = ACCESS;
            ACCESS: state_nxt = RESP;
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte k of the access lives at index+k, wrapping inside the array.
    assign idx1 = idx0 + MEM_AW'(1);
    assign idx2 = idx0 + MEM_AW'(2);
    assign idx3 = idx0 + MEM_AW'(3);
    assign b0   = mem[idx0];
    assign b1   = mem[idx1];
    assign b2   = mem[idx2];
    assign b3   = mem[idx3];

    always_comb begin
        illegal_f3 = we_q ? (f3_q > 3'b010) : ((f3_q == 3'b011) || (f3_q[2:1] == 2'b11));
`ifdef DMEM_MISALIGN_CHECK_EN
        misal = ((f3_q[1:0] == 2'b01) && idx0[0]) || ((f3_q[1:0] == 2'b10) && (idx0[1:0] != 2'b00));
`else
        misal = 1'b0;
`endif
        acc_err = illegal_f3 | misal;
    end

    always_comb begin
        load_data = 32'h0;
        case (f3_q)
            3'b000:  load_data = {{24{b0[7]}}, b0};
            3'b001:  load_data = {{16{b1[7]}}, b1, b0};
            3'b010:  load_data = {b3, b2, b1, b0};
            3'b100:  load_data = {24'h0, b0};
            3'b101:  load_data = {16'h0, b1, b0};
            default: load_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdy_en  <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            idx0    <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                idx0    <= bus.req_addr[MEM_AW-1:0];
                wdata_q <= bus.req_wdata;
                cnt     <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == ACCESS) begin
                rdata_q <= (acc_err || we_q) ? 32'h0 : load_data;
                err_q   <= acc_err;
            end
        end
    end

    // Array has no reset; an async reset forces IDLE, so no write can happen under reset.
    always_ff @(posedge clk) begin
        if (state == ACCESS && we_q && !acc_err) begin
            mem[idx0] <= wdata_q[7:0];
            if (f3_q[1:0] != 2'b00) mem[idx1] <= wdata_q[15:8];
            if (f3_q[1:0] == 2'b10) begin
                mem[idx2] <= wdata_q[23:16];
                mem[idx3] <= wdata_q[31:24];
            end
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed vector bench for data_mem_responder: LATENCY=2 instance for the data path, LATENCY=4 instance for mid-wait reset.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst2 = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    data_mem_responder_if ia ();
    data_mem_responder_if ib ();

    data_mem_responder #(.MEM_AW(12), .LATENCY(2)) dut_a (.clk(clk), .rst(rst),  .bus(ia));
    data_mem_responder #(.MEM_AW(12), .LATENCY(4)) dut_b (.clk(clk), .rst(rst2), .bus(ib));

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(input bit sel, input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            ib.req_valid = v; ib.req_we = we; ib.req_funct3 = f3; ib.req_addr = a; ib.req_wdata = wd;
        end else begin
            ia.req_valid = v; ia.req_we = we; ia.req_funct3 = f3; ia.req_addr = a; ia.req_wdata = wd;
        end
    endtask

    task automatic txn(input bit sel, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!(sel ? ib.req_ready : ia.req_ready) && n < 64) begin
            @(negedge clk);
            n++;
        end
        drv(sel, 1'b1, we, f3, a, wd);
        if (sel) ib.resp_ready = 1'b1; else ia.resp_ready = 1'b1;
        @(posedge clk);
        #1 drv(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(sel ? ib.resp_valid : ia.resp_valid) && lat < 64);
        rd = sel ? ib.resp_rdata : ia.resp_rdata;
        er = sel ? ib.resp_err : ia.resp_err;
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          cnt;

        drv(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drv(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        ia.resp_ready = 1'b0;
        ib.resp_ready = 1'b0;

        // Fill table: {we, funct3, addr, wdata, expected rdata, expected err}
        vt.push_back('{1'b1, 3'b010, 32'h100,  32'hDEADBEEF, 32'h0,        1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0});
        vt.push_back('{1'b1, 3'b010, 32'h20,   32'h0,        32'h0,        1'b0});
        vt.push_back('{1'b1, 3'b000, 32'h21,   32'h12345680, 32'h0,        1'b0});
        vt.push_back('{1'b0, 3'b000, 32'h21,   32'h0,        32'hFFFFFF80, 1'b0});
        vt.push_back('{1'b0, 3'b100, 32'h21,   32'h0,        32'h00000080, 1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h20,   32'h0,        32'h00008000, 1'b0});
        vt.push_back('{1'b1, 3'b010, 32'h40,   32'h11223344, 32'h0,        1'b0});
        vt.push_back('{1'b1, 3'b001, 32'h40,   32'h1234ABCD, 32'h0,        1'b0});
        vt.push_back('{1'b0, 3'b001, 32'h40,   32'h0,        32'hFFFFABCD, 1'b0});
        vt.push_back('{1'b0, 3'b101, 32'h40,   32'h0,        32'h0000ABCD, 1'b0});
        vt.push_back('{1'b0, 3'b101, 32'h42,   32'h0,        32'h00001122, 1'b0});
        vt.push_back('{1'b1, 3'b010, 32'h104,  32'h55667788, 32'h0,        1'b0});
`ifdef DMEM_MISALIGN_CHECK_EN
        vt.push_back('{1'b0, 3'b010, 32'h102,  32'h0,        32'h0,        1'b1});
        vt.push_back('{1'b1, 3'b010, 32'h101,  32'hCAFEF00D, 32'h0,        1'b1});
        vt.push_back('{1'b0, 3'b010, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h1100, 32'h0,        32'hDEADBEEF, 1'b0});
        vt.push_back('{1'b0, 3'b001, 32'h41,   32'h0,        32'h0,        1'b1});
`else
        vt.push_back('{1'b0, 3'b010, 32'h102,  32'h0,        32'h7788DEAD, 1'b0});
        vt.push_back('{1'b1, 3'b010, 32'h101,  32'hCAFEF00D, 32'h0,        1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h100,  32'h0,        32'hFEF00DEF, 1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h1100, 32'h0,        32'hFEF00DEF, 1'b0});
        vt.push_back('{1'b1, 3'b001, 32'hFFF,  32'h0000BEEF, 32'h0,        1'b0});
        vt.push_back('{1'b0, 3'b100, 32'h0,    32'h0,        32'h000000BE, 1'b0});
        vt.push_back('{1'b0, 3'b101, 32'hFFF,  32'h0,        32'h0000BEEF, 1'b0});
`endif
        vt.push_back('{1'b0, 3'b011, 32'h100,  32'h0,        32'h0,        1'b1});
        vt.push_back('{1'b0, 3'b110, 32'h20,   32'h0,        32'h0,        1'b1});
        vt.push_back('{1'b1, 3'b011, 32'h20,   32'hFFFFFFFF, 32'h0,        1'b1});
        vt.push_back('{1'b0, 3'b010, 32'h20,   32'h0,        32'h00008000, 1'b0});

        // Reset values while rst is held low
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'h0, ia.req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, ia.resp_valid}, 32'h0);
        chk("rst_resp_rdata", ia.resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, ia.resp_err}, 32'h0);
        rst  = 1'b1;
        rst2 = 1'b1;
        #1 chk("rel_req_ready_low", {31'h0, ia.req_ready}, 32'h0);
        @(negedge clk);
        chk("rel_req_ready_high", {31'h0, ia.req_ready}, 32'h1);

        for (int i = 0; i < vt.size(); i++) begin
            txn(1'b0, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
            chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vt[i].err});
            chk($sformatf("vec%0d_latency", i), lat, 32'd4);
        end

        // Backpressure: LW 0x20 with resp_ready held low for 5 cycles in RESP
        @(negedge clk);
        ia.resp_ready = 1'b0;
        drv(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        @(posedge clk);
        #1 drv(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!ia.resp_valid && cnt < 64);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_resp_valid", k), {31'h0, ia.resp_valid}, 32'h1);
            chk($sformatf("bp%0d_rdata", k), ia.resp_rdata, 32'h00008000);
            chk($sformatf("bp%0d_err", k), {31'h0, ia.resp_err}, 32'h0);
            chk($sformatf("bp%0d_req_ready", k), {31'h0, ia.req_ready}, 32'h0);
            @(negedge clk);
        end
        ia.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_after_resp_valid", {31'h0, ia.resp_valid}, 32'h0);
        chk("bp_after_req_ready", {31'h0, ia.req_ready}, 32'h1);

        // Reset during WAIT on the LATENCY=4 instance drops the store and the response
        txn(1'b1, 1'b1, 3'b010, 32'h10, 32'hA5A5A5A5, rd, er, lat);
        chk("b_preload_latency", lat, 32'd6);
        @(negedge clk);
        ib.resp_ready = 1'b1;
        drv(1'b1, 1'b1, 1'b1, 3'b010, 32'h10, 32'h00000055);
        @(posedge clk);
        #1 drv(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("b_rst_req_ready", {31'h0, ib.req_ready}, 32'h0);
        chk("b_rst_resp_valid", {31'h0, ib.resp_valid}, 32'h0);
        chk("b_rst_rdata", ib.resp_rdata, 32'h0);
        chk("b_rst_err", {31'h0, ib.resp_err}, 32'h0);
        repeat (2) @(negedge clk);
        rst2 = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ib.resp_valid) cnt++;
        end
        chk("b_no_response", cnt, 32'd0);
        txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        chk("b_mem_unchanged", rd, 32'hA5A5A5A5);
        chk("b_load_err", {31'h0, er}, 32'h0);
        chk("b_load_latency", lat, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
